// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Imported by the sequencer FSM and its next-PC select mux.
package pc_sequencer_pkg;

  localparam int PC_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_TRAP  = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_EXT      = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } trap_cause_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [PC_WIDTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC for an issuing instruction (mret > jump > branch > pc+4),
// flagging redirect targets that are not word aligned.
module pc_next_mux
  import pc_sequencer_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc_current,
  input  logic [PC_WIDTH-1:0] epc,
  input  logic                mret,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] target,
  output logic                misaligned
);

  logic redirect;

  // The sequential fall-through is never checked; only redirect targets can fault.
  always_comb begin
    target   = pc_current + PC_WIDTH'(4);
    redirect = 1'b0;
    if (mret) begin
      target   = epc;
      redirect = 1'b1;
    end else if (jump) begin
      target   = jump_target;
      redirect = 1'b1;
    end else if (branch_taken) begin
      target   = branch_target;
      redirect = 1'b1;
    end
    misaligned = redirect && is_misaligned(target);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot delay, fetch handshake with timeout, next-PC selection,
// stall, halt and one-cycle trap entry. Drives the pc register input every clock.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR  = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR   = 32'h0000_0100,
  parameter int                  BOOT_CYCLES   = 4,
  parameter int                  FETCH_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_current,
  output logic                imem_req,
  input  logic                imem_ready,
  output logic                inst_valid,
  input  logic                stall_req,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                mret,
  input  logic                trap_req,
  input  logic                halt_req,
  output logic [PC_WIDTH-1:0] PCNext,
  output logic [PC_WIDTH-1:0] epc,
  output logic [1:0]          trap_cause,
  output logic                halted
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT);

  seq_state_t          state, state_next;
  logic [BOOT_W-1:0]   boot_cnt, boot_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic [PC_WIDTH-1:0] fault_pc, fault_pc_next;
  trap_cause_t         pend_cause, pend_cause_next;
  trap_cause_t         cause_q;
  logic [PC_WIDTH-1:0] epc_q;
  logic [PC_WIDTH-1:0] mux_target;
  logic                mux_misaligned;

  pc_next_mux u_mux (
    .pc_current   (pc_current),
    .epc          (epc_q),
    .mret         (mret),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .target       (mux_target),
    .misaligned   (mux_misaligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_BOOT;
      boot_cnt   <= '0;
      wait_cnt   <= '0;
      fault_pc   <= '0;
      pend_cause <= CAUSE_NONE;
      epc_q      <= '0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state      <= state_next;
      boot_cnt   <= boot_next;
      wait_cnt   <= wait_next;
      fault_pc   <= fault_pc_next;
      pend_cause <= pend_cause_next;
      // The fault is committed during the single TRAP cycle; mret leaves it intact.
      if (state == ST_TRAP) begin
        epc_q   <= fault_pc;
        cause_q <= pend_cause;
      end
    end
  end

  always_comb begin
    state_next      = state;
    boot_next       = boot_cnt;
    wait_next       = wait_cnt;
    fault_pc_next   = fault_pc;
    pend_cause_next = pend_cause;
    PCNext          = pc_current;
    imem_req        = 1'b0;
    inst_valid      = 1'b0;
    halted          = 1'b0;

    unique case (state)
      ST_BOOT: begin
        PCNext = RESET_VECTOR;
        if (boot_cnt == BOOT_LAST) state_next = ST_FETCH;
        else                       boot_next  = boot_cnt + BOOT_W'(1);
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          state_next = ST_ISSUE;
          wait_next  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next      = ST_TRAP;
          wait_next       = '0;
          fault_pc_next   = pc_current;
          pend_cause_next = CAUSE_TIMEOUT;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end

      // Trap beats stall; a faulting redirect holds the PC so epc names the culprit.
      ST_ISSUE: begin
        inst_valid = 1'b1;
        if (trap_req) begin
          state_next      = ST_TRAP;
          fault_pc_next   = pc_current;
          pend_cause_next = CAUSE_EXT;
        end else if (stall_req) begin
          state_next = ST_ISSUE;
        end else if (mux_misaligned) begin
          state_next      = ST_TRAP;
          fault_pc_next   = pc_current;
          pend_cause_next = CAUSE_MISALIGN;
        end else begin
          PCNext     = mux_target;
          state_next = halt_req ? ST_HALT : ST_FETCH;
        end
      end

      ST_TRAP: begin
        PCNext     = TRAP_VECTOR;
        state_next = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) state_next = ST_FETCH;
      end

      default: state_next = ST_BOOT;
    endcase
  end

  assign epc        = epc_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios pinned with literal values, then random traffic
// compared every cycle against an instruction-level model of the sequencer.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VECTOR  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR   = 32'h0000_0100;
  localparam int          BOOT_CYCLES   = 4;
  localparam int          FETCH_TIMEOUT = 15;

  localparam int MODE_BOOT  = 0;
  localparam int MODE_FETCH = 1;
  localparam int MODE_ISSUE = 2;
  localparam int MODE_TRAP  = 3;
  localparam int MODE_HALT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_reg;
  logic        imem_req, imem_ready, inst_valid, stall_req, branch_taken, jump, mret;
  logic        trap_req, halt_req, halted;
  logic [31:0] branch_target, jump_target, pc_next, epc;
  logic [1:0]  trap_cause;

  // Values the next cycle will drive.
  logic        n_ready = 1'b1, n_stall = 1'b0, n_branch = 1'b0, n_jump = 1'b0;
  logic        n_mret = 1'b0, n_trap = 1'b0, n_halt = 1'b0;
  logic [31:0] n_btgt = 32'h0, n_jtgt = 32'h0;

  int checks = 0;
  int failures = 0;

  // Model state: what the sequencer is doing and the architectural PC it has produced.
  int          m_mode, m_boot_seen, m_misses, m_fault_cause;
  logic [31:0] m_pc, m_epc, m_fault_pc;
  logic [1:0]  m_cause;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pc_current   (pc_reg),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .inst_valid   (inst_valid),
    .stall_req    (stall_req),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .mret         (mret),
    .trap_req     (trap_req),
    .halt_req     (halt_req),
    .PCNext       (pc_next),
    .epc          (epc),
    .trap_cause   (trap_cause),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // The pc register the sequencer steers.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= RESET_VECTOR;
    else      pc_reg <= pc_next;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_BOOT; m_boot_seen = 0; m_misses = 0;
    m_pc = RESET_VECTOR; m_epc = 32'h0; m_cause = 2'd0;
    m_fault_pc = 32'h0; m_fault_cause = 0;
  endtask

  // Predict this cycle's outputs, compare, then advance the model across the coming edge.
  task automatic model_cycle();
    logic [31:0] exp_next, tgt;
    logic        exp_req, exp_valid, exp_halted, redirect;
    int          nxt;
    exp_next = m_pc; exp_req = 1'b0; exp_valid = 1'b0; exp_halted = 1'b0; nxt = m_mode;
    case (m_mode)
      MODE_BOOT: begin
        exp_next = RESET_VECTOR;
        m_boot_seen++;
        if (m_boot_seen == BOOT_CYCLES) nxt = MODE_FETCH;
      end
      MODE_FETCH: begin
        exp_req = 1'b1;
        if (imem_ready) begin
          m_misses = 0; nxt = MODE_ISSUE;
        end else begin
          m_misses++;
          if (m_misses > FETCH_TIMEOUT) begin
            m_misses = 0; m_fault_pc = m_pc; m_fault_cause = 3; nxt = MODE_TRAP;
          end
        end
      end
      MODE_ISSUE: begin
        exp_valid = 1'b1;
        if (trap_req) begin
          m_fault_pc = m_pc; m_fault_cause = 1; nxt = MODE_TRAP;
        end else if (!stall_req) begin
          redirect = mret | jump | branch_taken;
          if (mret)              tgt = m_epc;
          else if (jump)         tgt = jump_target;
          else if (branch_taken) tgt = branch_target;
          else                   tgt = m_pc + 32'd4;
          if (redirect && (tgt % 4) != 0) begin
            m_fault_pc = m_pc; m_fault_cause = 2; nxt = MODE_TRAP;
          end else begin
            exp_next = tgt;
            nxt = halt_req ? MODE_HALT : MODE_FETCH;
          end
        end
      end
      MODE_TRAP: begin
        exp_next = TRAP_VECTOR;
        nxt = MODE_FETCH;
      end
      default: begin
        exp_halted = 1'b1;
        if (!halt_req) nxt = MODE_FETCH;
      end
    endcase
    check_output("pc_reg", pc_reg, m_pc);
    check_output("PCNext", pc_next, exp_next);
    check_output("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    check_output("inst_valid", {31'h0, inst_valid}, {31'h0, exp_valid});
    check_output("halted", {31'h0, halted}, {31'h0, exp_halted});
    check_output("epc", epc, m_epc);
    check_output("trap_cause", {30'h0, trap_cause}, {30'h0, m_cause});
    if (m_mode == MODE_TRAP) begin
      m_epc = m_fault_pc;
      m_cause = 2'(m_fault_cause);
    end
    m_pc = exp_next;
    m_mode = nxt;
  endtask

  task automatic drive_inputs();
    imem_ready = n_ready; stall_req = n_stall; branch_taken = n_branch; branch_target = n_btgt;
    jump = n_jump; jump_target = n_jtgt; mret = n_mret; trap_req = n_trap; halt_req = n_halt;
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    #1 drive_inputs();
    #3 model_cycle();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    drive_inputs();
    #3 model_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_PCNext"}, pc_next, RESET_VECTOR);
    check_output({tag, "_imem_req"}, {31'h0, imem_req}, 32'h0);
    check_output({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
    check_output({tag, "_halted"}, {31'h0, halted}, 32'h0);
    check_output({tag, "_epc"}, epc, 32'h0);
    check_output({tag, "_cause"}, {30'h0, trap_cause}, 32'h0);
  endtask

  task automatic random_inputs(inout int drought);
    if (drought > 0) begin
      drought--; n_ready = 1'b0;
    end else begin
      if ($urandom_range(0, 149) == 0) drought = 20;
      n_ready = ($urandom_range(0, 3) != 0);
    end
    n_stall  = ($urandom_range(0, 3) == 0);
    n_trap   = ($urandom_range(0, 19) == 0);
    n_mret   = ($urandom_range(0, 7) == 0);
    n_jump   = ($urandom_range(0, 5) == 0);
    n_branch = ($urandom_range(0, 3) == 0);
    n_halt   = ($urandom_range(0, 15) == 0);
    n_jtgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
    n_btgt   = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) n_jtgt[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 7) == 0) n_btgt[1:0] = 2'($urandom_range(1, 3));
  endtask

  initial begin
    int drought;
    drought = 0;
    drive_inputs();
    model_reset();
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    release_reset();

    // Boot: four cycles at the reset vector, then 0,4,8 with zero-wait memory.
    repeat (3) apply_stimulus();
    check_output("boot4_PCNext", pc_next, 32'h0);
    check_output("boot4_imem_req", {31'h0, imem_req}, 32'h0);
    apply_stimulus();
    check_output("fetch0_imem_req", {31'h0, imem_req}, 32'h1);
    apply_stimulus();
    check_output("issue0_PCNext", pc_next, 32'h4);
    check_output("issue0_valid", {31'h0, inst_valid}, 32'h1);
    apply_stimulus();
    check_output("fetch4_valid", {31'h0, inst_valid}, 32'h0);
    apply_stimulus();
    check_output("issue4_PCNext", pc_next, 32'h8);

    // Fetch timeout at 0x8, then mret from the handler.
    n_ready = 1'b0;
    repeat (16) apply_stimulus();
    check_output("timeout_last_fetch", pc_next, 32'h8);
    apply_stimulus();
    check_output("timeout_trap_PCNext", pc_next, 32'h100);
    n_ready = 1'b1;
    apply_stimulus();
    check_output("timeout_epc", epc, 32'h8);
    check_output("timeout_cause", {30'h0, trap_cause}, 32'h3);
    n_mret = 1'b1;
    apply_stimulus();
    check_output("mret_PCNext", pc_next, 32'h8);
    n_mret = 1'b0;
    repeat (3) apply_stimulus();

    // Stall three cycles at 0xC, then stall with trap.
    n_stall = 1'b1;
    repeat (3) begin
      apply_stimulus();
      check_output("stall_PCNext", pc_next, 32'hC);
    end
    n_trap = 1'b1;
    apply_stimulus();
    check_output("stall_trap_hold", pc_next, 32'hC);
    n_stall = 1'b0; n_trap = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("ext_epc", epc, 32'hC);
    check_output("ext_cause", {30'h0, trap_cause}, 32'h1);

    // Jump/branch priority and misaligned jump.
    n_jump = 1'b1; n_jtgt = 32'h10;
    apply_stimulus();
    apply_stimulus();
    n_jtgt = 32'h40; n_branch = 1'b1; n_btgt = 32'h80;
    apply_stimulus();
    check_output("jump_over_branch", pc_next, 32'h40);
    n_jump = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("branch_only", pc_next, 32'h80);
    n_branch = 1'b0; n_jump = 1'b1; n_jtgt = 32'h20;
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    n_jtgt = 32'h42;
    apply_stimulus();
    check_output("misalign_hold", pc_next, 32'h20);
    n_jump = 1'b0;
    apply_stimulus();
    check_output("misalign_trap_PCNext", pc_next, 32'h100);
    apply_stimulus();
    check_output("misalign_epc", epc, 32'h20);
    check_output("misalign_cause", {30'h0, trap_cause}, 32'h2);

    // Sequential wrap past the top of the address space.
    n_jump = 1'b1; n_jtgt = 32'hFFFF_FFFC;
    apply_stimulus();
    n_jump = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("wrap_PCNext", pc_next, 32'h0);
    apply_stimulus();

    // Halt, resume, then reset in the middle of a fetch.
    n_halt = 1'b1;
    apply_stimulus();
    apply_stimulus();
    check_output("halt_flag", {31'h0, halted}, 32'h1);
    check_output("halt_PCNext", pc_next, 32'h4);
    apply_stimulus();
    n_halt = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("resume_imem_req", {31'h0, imem_req}, 32'h1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midfetch");
    model_reset();
    release_reset();

    // Random traffic against the model, with one extra reset midway.
    for (int i = 0; i < 3000; i++) begin
      random_inputs(drought);
      apply_stimulus();
      if (i == 1500) begin
        #2 rst = 1'b0;
        #1 check_reset_outputs("rand_reset");
        model_reset();
        release_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
